round_controller: RTL and testbench

ROUND_CONTROLLER -- requirements
Module: round_controller

---
 rtl/round_controller_pkg.sv | 34 +++
 rtl/round_controller_action_latch.sv | 55 +++++
 rtl/round_controller.sv | 120 ++++++++++++
 tb/tb_round_controller.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/round_controller_pkg.sv
// Shared encodings for the round controller and the player blocks: action codes,
// game-result codes and the controller's FSM states.
package round_controller_pkg;

  localparam logic [2:0] ACT_KICK   = 3'b000;
  localparam logic [2:0] ACT_PUNCH  = 3'b001;
  localparam logic [2:0] ACT_AWAIT  = 3'b010;
  localparam logic [2:0] ACT_JUMP   = 3'b011;
  localparam logic [2:0] ACT_LEFT1  = 3'b100;
  localparam logic [2:0] ACT_LEFT2  = 3'b101;
  localparam logic [2:0] ACT_RIGHT1 = 3'b110;
  localparam logic [2:0] ACT_RIGHT2 = 3'b111;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam logic [1:0] ST_COLLECT = 2'b00;
  localparam logic [1:0] ST_ISSUE   = 2'b01;
  localparam logic [1:0] ST_SETTLE  = 2'b10;
  localparam logic [1:0] ST_OVER    = 2'b11;

  // Game result implied by the post-round health pair; WIN_NONE means play on.
  function automatic logic [1:0] settle_result(input logic [1:0] h1, input logic [1:0] h2);
    logic [1:0] r;
    r = WIN_NONE;
    if (h1 == 2'b00 && h2 == 2'b00) r = WIN_DRAW;
    else if (h2 == 2'b00)           r = WIN_P1;
    else if (h1 == 2'b00)           r = WIN_P2;
    return r;
  endfunction

endpackage

// File: rtl/round_controller_action_latch.sv
// Per-player action capture: first strobe of a round wins, a missing action
// defaults to await on timeout, and the committed flag is cleared between rounds.
module action_latch
  import round_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_i,
  input  logic       btn_valid_i,
  input  logic [2:0] btn_code_i,
  input  logic       timeout_i,
  input  logic       clear_i,
  output logic       committed_o,
  output logic       commit_now_o,
  output logic [2:0] action_o
);

  logic       committed_q = 1'b0;
  logic       committed_d;
  logic [2:0] action_q = ACT_AWAIT;
  logic [2:0] action_d;
  logic       take;

  assign take = sample_i && btn_valid_i && !committed_q;

  always_comb begin
    committed_d = committed_q;
    action_d    = action_q;
    if (clear_i) begin
      // The action value is kept so the outputs hold until the next commit.
      committed_d = 1'b0;
    end else if (take) begin
      committed_d = 1'b1;
      action_d    = btn_code_i;
    end else if (timeout_i && !committed_q) begin
      committed_d = 1'b1;
      action_d    = ACT_AWAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      committed_q <= 1'b0;
      action_q    <= ACT_AWAIT;
    end else begin
      committed_q <= committed_d;
      action_q    <= action_d;
    end
  end

  assign committed_o  = committed_q;
  assign commit_now_o = committed_q | take;
  assign action_o     = action_q;

endmodule

// File: rtl/round_controller.sv
// Two-player round sequencer: collects one action per player, issues them as a
// single strobe, then settles health to decide whether the game continues.
module round_controller
  import round_controller_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_valid1,
  input  logic [2:0] btn_code1,
  input  logic       btn_valid2,
  input  logic [2:0] btn_code2,
  input  logic [1:0] health1,
  input  logic [1:0] health2,
  output logic [2:0] action1,
  output logic [2:0] action2,
  output logic       actionEnable,
  output logic       isGameOver,
  output logic [1:0] winner,
  output logic [7:0] round_count
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  logic [1:0]    state_q = ST_COLLECT;
  logic [1:0]    state_d;
  logic [TW-1:0] timer_q = '0;
  logic [TW-1:0] timer_d;
  logic [7:0]    round_q = 8'd0;
  logic [7:0]    round_d;
  logic [1:0]    winner_q = WIN_NONE;
  logic [1:0]    winner_d;

  logic       in_collect, timeout, clear;
  logic       committed1, committed2, now1, now2;
  logic [1:0] result;

  assign in_collect = (state_q == ST_COLLECT);
  assign timeout    = in_collect && (timer_q == TMAX);
  assign result     = settle_result(health1, health2);
  assign clear      = (state_q == ST_SETTLE) && (result == WIN_NONE);

  action_latch u_latch1 (
    .clk          (clk),
    .reset        (reset),
    .sample_i     (in_collect),
    .btn_valid_i  (btn_valid1),
    .btn_code_i   (btn_code1),
    .timeout_i    (timeout),
    .clear_i      (clear),
    .committed_o  (committed1),
    .commit_now_o (now1),
    .action_o     (action1)
  );

  action_latch u_latch2 (
    .clk          (clk),
    .reset        (reset),
    .sample_i     (in_collect),
    .btn_valid_i  (btn_valid2),
    .btn_code_i   (btn_code2),
    .timeout_i    (timeout),
    .clear_i      (clear),
    .committed_o  (committed2),
    .commit_now_o (now2),
    .action_o     (action2)
  );

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    round_d  = round_q;
    winner_d = winner_q;
    case (state_q)
      ST_COLLECT: begin
        if ((now1 && now2) || timeout) begin
          // Count on entry so round_count already reflects the round being issued.
          state_d = ST_ISSUE;
          if (round_q != 8'hFF) round_d = round_q + 8'd1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_ISSUE: state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (result != WIN_NONE) begin
          state_d  = ST_OVER;
          winner_d = result;
        end else begin
          state_d = ST_COLLECT;
          timer_d = '0;
        end
      end
      ST_OVER: state_d = ST_OVER;
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_COLLECT;
      timer_q  <= '0;
      round_q  <= 8'd0;
      winner_q <= WIN_NONE;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      round_q  <= round_d;
      winner_q <= winner_d;
    end
  end

  assign actionEnable = (state_q == ST_ISSUE);
  assign isGameOver   = (state_q == ST_OVER);
  assign winner       = winner_q;
  assign round_count  = round_q;

endmodule

// File: tb/tb_round_controller.sv
// Randomized round-level bench: each round's issue cycle, actions, count and
// result are predicted from first-strobe/timeout/health rules.
module tb_round_controller;

  localparam int TO = 16;
  localparam int NONE = 999;

  logic       clk;
  logic       reset;
  logic       btn_valid1, btn_valid2;
  logic [2:0] btn_code1, btn_code2;
  logic [1:0] health1, health2;
  logic [2:0] action1, action2;
  logic       actionEnable, isGameOver;
  logic [1:0] winner;
  logic [7:0] round_count;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_rounds = 0;

  round_controller #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_valid1   (btn_valid1),
    .btn_code1    (btn_code1),
    .btn_valid2   (btn_valid2),
    .btn_code2    (btn_code2),
    .health1      (health1),
    .health2      (health2),
    .action1      (action1),
    .action2      (action2),
    .actionEnable (actionEnable),
    .isGameOver   (isGameOver),
    .winner       (winner),
    .round_count  (round_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    btn_valid1 = 1'b0;
    btn_valid2 = 1'b0;
    btn_code1  = 3'b000;
    btn_code2  = 3'b000;
    health1    = 2'b11;
    health2    = 2'b11;
  endtask

  task automatic chk_reset_vals(input string where);
    chk({where, "_en"},     32'(actionEnable), 32'd0);
    chk({where, "_over"},   32'(isGameOver),   32'd0);
    chk({where, "_winner"}, 32'(winner),       32'd0);
    chk({where, "_rounds"}, 32'(round_count),  32'd0);
    chk({where, "_a1"},     32'(action1),      32'd2);
    chk({where, "_a2"},     32'(action2),      32'd2);
  endtask

  task automatic do_reset(input string where);
    reset = 1'b1;
    idle_inputs();
    step();
    reset = 1'b0;
    exp_rounds = 0;
    chk_reset_vals(where);
  endtask

  function automatic logic [1:0] exp_winner(input logic [1:0] h1, input logic [1:0] h2);
    if (h1 == 0 && h2 == 0) return 2'd3;
    if (h2 == 0) return 2'd1;
    if (h1 == 0) return 2'd2;
    return 2'd0;
  endfunction

  // One round from the first COLLECT cycle. fN = offset of player N's first
  // strobe (NONE = silent); x1off/x1code add a later player-1 strobe.
  task automatic run_round(input int f1, input int f2, input logic [2:0] c1, input logic [2:0] c2,
                           input logic [1:0] h1, input logic [1:0] h2, input bit noise,
                           input int x1off, input logic [2:0] x1code, input bit rst_issue,
                           output bit over);
    int last, e;
    logic [2:0] e1, e2;
    logic [1:0] w;
    over = 1'b0;
    last = (f1 > f2) ? f1 : f2;
    e  = (last < TO - 1) ? last : TO - 1;
    e1 = (f1 <= e) ? c1 : 3'b010;
    e2 = (f2 <= e) ? c2 : 3'b010;
    for (int off = 0; off <= e; off++) begin
      btn_valid1 = (off == f1) || (off == x1off) || (noise && off > f1 && $urandom_range(0, 2) == 0);
      btn_code1  = (off == f1) ? c1 : (off == x1off) ? x1code : 3'($urandom);
      btn_valid2 = (off == f2) || (noise && off > f2 && $urandom_range(0, 2) == 0);
      btn_code2  = (off == f2) ? c2 : 3'($urandom);
      chk("collect_en", 32'(actionEnable), 32'd0);
      step();
    end
    // ISSUE cycle: any strobes here must be dropped.
    btn_valid1 = noise & 1'($urandom);
    btn_code1  = 3'($urandom);
    btn_valid2 = noise & 1'($urandom);
    btn_code2  = 3'($urandom);
    if (exp_rounds < 255) exp_rounds++;
    chk("issue_en",     32'(actionEnable), 32'd1);
    chk("issue_a1",     32'(action1),      32'(e1));
    chk("issue_a2",     32'(action2),      32'(e2));
    chk("issue_rounds", 32'(round_count),  32'(exp_rounds));
    if (rst_issue) begin
      reset = 1'b1;
      step();
      reset = 1'b0;
      idle_inputs();
      exp_rounds = 0;
      chk_reset_vals("rst_issue");
      return;
    end
    step();
    // SETTLE cycle: health reflects the round.
    health1    = h1;
    health2    = h2;
    btn_valid1 = noise & 1'($urandom);
    btn_code1  = 3'($urandom);
    btn_valid2 = noise & 1'($urandom);
    btn_code2  = 3'($urandom);
    chk("settle_en",   32'(actionEnable), 32'd0);
    chk("settle_over", 32'(isGameOver),   32'd0);
    chk("settle_a1",   32'(action1),      32'(e1));
    step();
    idle_inputs();
    w = exp_winner(h1, h2);
    chk("post_over",   32'(isGameOver),   32'(w != 2'd0));
    chk("post_winner", 32'(winner),       32'(w));
    chk("post_en",     32'(actionEnable), 32'd0);
    over = (w != 2'd0);
  endtask

  task automatic over_hold(input logic [1:0] w);
    for (int i = 0; i < 50; i++) begin
      btn_valid1 = 1'($urandom);
      btn_code1  = 3'($urandom);
      btn_valid2 = 1'($urandom);
      btn_code2  = 3'($urandom);
      health1    = 2'($urandom);
      health2    = 2'($urandom);
      chk("over_en",     32'(actionEnable), 32'd0);
      chk("over_flag",   32'(isGameOver),   32'd1);
      chk("over_winner", 32'(winner),       32'(w));
      chk("over_rounds", 32'(round_count),  32'(exp_rounds));
      step();
    end
    idle_inputs();
  endtask

  initial begin
    bit ov;
    int f1, f2;
    reset = 1'b0;
    idle_inputs();
    #1;
    chk_reset_vals("pwr");
    do_reset("rst");

    // Kick at cycle 2, punch at cycle 5 -> issue at cycle 6, round 1.
    run_round(2, 5, 3'b000, 3'b001, 2'b11, 2'b11, 1'b0, NONE, 3'b000, 1'b0, ov);
    // P1 jump only -> timeout after 16 COLLECT cycles, P2 defaults to await.
    run_round(3, NONE, 3'b011, 3'b000, 2'b10, 2'b01, 1'b0, NONE, 3'b000, 1'b0, ov);
    // Second strobe (right1) in the same round is ignored.
    run_round(0, 3, 3'b100, 3'b111, 2'b11, 2'b11, 1'b0, 1, 3'b110, 1'b0, ov);
    // Commit exactly on the timeout cycle still counts.
    run_round(TO - 1, 0, 3'b101, 3'b110, 2'b11, 2'b11, 1'b0, NONE, 3'b000, 1'b0, ov);

    for (int r = 0; r < 40; r++) begin
      f1 = ($urandom_range(0, 5) == 0) ? NONE : int'($urandom_range(0, TO + 2));
      f2 = ($urandom_range(0, 5) == 0) ? NONE : int'($urandom_range(0, TO + 2));
      run_round(f1, f2, 3'($urandom), 3'($urandom), 2'($urandom_range(1, 3)),
                2'($urandom_range(1, 3)), 1'b1, NONE, 3'b000, 1'b0, ov);
    end

    // Drive round_count into saturation.
    for (int r = 0; r < 260; r++)
      run_round(0, 0, 3'($urandom), 3'($urandom), 2'b01, 2'b10, 1'b1, NONE, 3'b000, 1'b0, ov);
    chk("sat_rounds", 32'(round_count), 32'd255);

    // P2 health hits zero -> P1 wins, then strobes are ignored, then reset in OVER.
    run_round(1, 2, 3'b000, 3'b001, 2'b10, 2'b00, 1'b0, NONE, 3'b000, 1'b0, ov);
    chk("p1win_flag", 32'(ov), 32'd1);
    over_hold(2'd1);
    do_reset("rst_over1");

    run_round(0, 0, 3'b001, 3'b001, 2'b00, 2'b00, 1'b0, NONE, 3'b000, 1'b0, ov);
    over_hold(2'd3);
    do_reset("rst_over3");

    run_round(4, 1, 3'b111, 3'b000, 2'b00, 2'b01, 1'b1, NONE, 3'b000, 1'b0, ov);
    over_hold(2'd2);
    do_reset("rst_over2");

    // Reset during ISSUE, then a clean round starts counting from 1 again.
    run_round(1, 1, 3'b011, 3'b100, 2'b11, 2'b11, 1'b0, NONE, 3'b000, 1'b1, ov);
    run_round(0, NONE, 3'b110, 3'b000, 2'b11, 2'b11, 1'b0, NONE, 3'b000, 1'b0, ov);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
